// File: rtl/ps2_pkg.sv
// ps2_pkg: constants, the frame FSM state encoding and small helpers
// shared by the PS/2 key event receiver and its event FIFO.
//   PS2_EXT_CODE / PS2_BRK_CODE : prefix bytes folded into the next event
//   PS2_DATA_BITS               : data bits per device-to-host frame
//   EVT_W                       : packed event width, {ext, brk, scan[7:0]}
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_CODE  = 8'hE0;
  localparam logic [7:0] PS2_BRK_CODE  = 8'hF0;
  localparam int         PS2_DATA_BITS = 8;
  localparam int         EVT_W         = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Odd parity holds when the data bits plus the parity bit carry an odd
  // number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  function automatic logic [EVT_W-1:0] pack_evt(input logic ext, input logic brk,
                                                input logic [7:0] scan);
    return {ext, brk, scan};
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: W x DEPTH synchronous event FIFO (DEPTH a power of 2, >= 2).
// Pointers wrap naturally at DEPTH; storage is not reset, only the
// pointers and the occupancy count are.
// Ports:
//   clk100, reset : clock, asynchronous active-high reset
//   i_push, i_din : write request and data; ignored while full unless a
//                   pop happens in the same cycle
//   i_pop         : read request; ignored while empty
//   o_dout        : head entry
//   o_full, o_empty, o_count : occupancy status
module ps2_evt_fifo import ps2_pkg::*; #(
  parameter int W     = EVT_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk100,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd];
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk100) begin
    if (w_do_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx: PS/2 keyboard receiver producing decoded key events.
// Synchronizes and glitch-filters ps2clk, frames 11-bit device-to-host
// words, checks start/odd-parity/stop, folds E0/F0 prefixes into one event
// and queues events in ps2_evt_fifo behind a valid/ready handshake.
// Optional build macro: PS2_TYPEMATIC_FILTER_EN suppresses auto-repeated
// make events that match the last make seen.
// Ports:
//   clk100, reset           : 100 MHz clock, asynchronous active-high reset
//   ps2clk, ps2data         : raw asynchronous PS/2 pins
//   evt_scan/break/ext      : head event fields (0 while no event is held)
//   evt_valid, evt_ready    : FIFO handshake, pop when both are 1
//   frame_err               : 1-cycle pulse, bad start/parity/stop or timeout
//   overflow                : 1-cycle pulse, event dropped on a full FIFO
module ps2_key_event_rx import ps2_pkg::*; #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] evt_scan,
  output logic       evt_break,
  output logic       evt_ext,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic [FW-1:0]    r_fcnt;
  logic             r_filt;
  logic             w_fstep, w_fflip, w_fall, w_bit;
  logic [TW-1:0]    r_tocnt;
  logic             w_timeout;
  ps2_state_t       r_state, w_state_nxt;
  logic [2:0]       r_bitcnt, w_bitcnt_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_par, w_par_nxt;
  logic             w_err, w_done, w_flag_clr;
  logic             r_frame_err;
  logic             r_byte_vld;
  logic [7:0]       r_byte;
  logic             r_ext_flag, r_brk_flag;
  logic             w_is_ext, w_is_brk, w_evt_cand, w_suppress, w_push, w_pop;
  logic [EVT_W-1:0] w_evt, w_head;
  logic             w_full, w_empty;
  logic [CW-1:0]    w_count;

  // Stage: two-flop synchronizers; idle PS/2 lines are high.
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Stage: glitch filter. The run counter only advances while the
  // synchronized clock disagrees with the filtered level; any agreeing
  // sample restarts the run.
  assign w_fstep = (r_clk_s2 != r_filt);
  assign w_fflip = w_fstep && (r_fcnt == FW'(FILTER_LEN - 1));
  assign w_fall  = w_fflip && r_filt;
  assign w_bit   = r_dat_s2;

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      r_fcnt <= '0;
      r_filt <= 1'b1;
    end else if (!w_fstep) begin
      r_fcnt <= '0;
    end else if (w_fflip) begin
      r_fcnt <= '0;
      r_filt <= r_clk_s2;
    end else begin
      r_fcnt <= r_fcnt + FW'(1);
    end
  end

  // Stage: frame timeout. A fall edge in the expiring cycle takes priority.
  assign w_timeout = (r_state != IDLE) && !w_fall &&
                     (r_tocnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset)                             r_tocnt <= '0;
    else if (r_state == IDLE || w_fall)    r_tocnt <= '0;
    else if (!w_timeout)                   r_tocnt <= r_tocnt + TW'(1);
  end

  // Stage: frame FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_par_nxt    = r_par;
    w_err        = 1'b0;
    w_done       = 1'b0;
    w_flag_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          if (!w_bit) begin
            w_state_nxt  = DATA;
            w_bitcnt_nxt = '0;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_fall) begin
          w_shift_nxt = {w_bit, r_shift[7:1]};
          if (r_bitcnt == 3'(PS2_DATA_BITS - 1)) w_state_nxt = PARITY;
          else                                   w_bitcnt_nxt = r_bitcnt + 3'd1;
        end
      end
      PARITY: begin
        if (w_fall) begin
          w_par_nxt   = w_bit;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          if (w_bit && odd_parity_ok(r_shift, r_par)) begin
            w_done = 1'b1;
          end else begin
            w_err      = 1'b1;
            w_flag_clr = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = IDLE;
      w_err       = 1'b1;
      w_flag_clr  = 1'b1;
    end
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bitcnt    <= '0;
      r_frame_err <= 1'b0;
      r_byte_vld  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_frame_err <= w_err;
      r_byte_vld  <= w_done;
    end
  end

  always_ff @(posedge clk100) begin
    r_shift <= w_shift_nxt;
    r_par   <= w_par_nxt;
    if (w_done) r_byte <= r_shift;
  end

  // Stage: prefix folding, one cycle after the byte completes.
  assign w_is_ext   = (r_byte == PS2_EXT_CODE);
  assign w_is_brk   = (r_byte == PS2_BRK_CODE);
  assign w_evt_cand = r_byte_vld && !w_is_ext && !w_is_brk;
  assign w_evt      = pack_evt(r_ext_flag, r_brk_flag, r_byte);

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      r_ext_flag <= 1'b0;
      r_brk_flag <= 1'b0;
    end else if (w_flag_clr) begin
      r_ext_flag <= 1'b0;
      r_brk_flag <= 1'b0;
    end else if (r_byte_vld) begin
      if (w_is_ext) begin
        r_ext_flag <= 1'b1;
      end else if (w_is_brk) begin
        r_brk_flag <= 1'b1;
      end else begin
        r_ext_flag <= 1'b0;
        r_brk_flag <= 1'b0;
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       r_last_vld, r_last_ext;
  logic [7:0] r_last_scan;
  logic       w_match;

  assign w_match    = r_last_vld && (r_last_ext == r_ext_flag) && (r_last_scan == r_byte);
  assign w_suppress = w_evt_cand && !r_brk_flag && w_match;

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      r_last_vld  <= 1'b0;
      r_last_ext  <= 1'b0;
      r_last_scan <= '0;
    end else if (w_evt_cand) begin
      if (r_brk_flag) begin
        if (w_match) r_last_vld <= 1'b0;
      end else if (!w_match) begin
        r_last_vld  <= 1'b1;
        r_last_ext  <= r_ext_flag;
        r_last_scan <= r_byte;
      end
    end
  end
`else
  assign w_suppress = 1'b0;
`endif

  assign w_push = w_evt_cand && !w_suppress;

  // Stage: event FIFO and handshake.
  assign evt_valid = (w_count != '0);
  assign w_pop     = evt_valid && evt_ready;
  assign overflow  = w_push && w_full && !w_pop;
  assign frame_err = r_frame_err;
  assign evt_scan  = w_empty ? 8'h00 : w_head[7:0];
  assign evt_break = w_empty ? 1'b0  : w_head[8];
  assign evt_ext   = w_empty ? 1'b0  : w_head[9];

  ps2_evt_fifo #(
    .W     (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk100  (clk100),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_evt),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_ps2_key_event_rx.sv
`timescale 1ns/1ps
module tb_ps2_key_event_rx;

  localparam int FILT  = 8;
  localparam int TMO   = 2000;
  localparam int DEPTH = 4;
  localparam int H     = 30;   // PS/2 half period in clk100 cycles

  logic       clk100 = 1'b0;
  logic       reset = 1'b1;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_scan;
  logic       evt_break, evt_ext, evt_valid, frame_err, overflow;

  always #5 clk100 = ~clk100;

  ps2_key_event_rx #(
    .FILTER_LEN     (FILT),
    .TIMEOUT_CYCLES (TMO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk100    (clk100),
    .reset     (reset),
    .ps2clk    (ps2clk),
    .ps2data   (ps2data),
    .evt_scan  (evt_scan),
    .evt_break (evt_break),
    .evt_ext   (evt_ext),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  int n_chk = 0, n_fail = 0;
  int exp_err = 0, exp_ovf = 0, got_err = 0, got_ovf = 0, vld_cycles = 0;
  logic [9:0] exp_q[$];
  logic [9:0] got_log[$];
  logic m_ext = 1'b0, m_brk = 1'b0;
  logic m_lm_vld = 1'b0, m_lm_ext = 1'b0;
  logic [7:0] m_lm_scan = 8'h00;
  logic run_cmp = 1'b0;
  logic rand_on = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  // Reference model: one call per received byte, at frame level.
  task automatic model_byte(input logic [7:0] b, input bit good);
    logic [9:0] e;
    bit keep;
    keep = 1'b1;
    if (!good) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
      return;
    end
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      e = {m_ext, m_brk, b};
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (!m_brk) begin
        if (m_lm_vld && m_lm_ext == m_ext && m_lm_scan == b) keep = 1'b0;
        else begin
          m_lm_vld  = 1'b1;
          m_lm_ext  = m_ext;
          m_lm_scan = b;
        end
      end else if (m_lm_vld && m_lm_ext == m_ext && m_lm_scan == b) begin
        m_lm_vld = 1'b0;
      end
`endif
      if (keep) begin
        if (exp_q.size() >= DEPTH) exp_ovf++;
        else exp_q.push_back(e);
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Sends nbits of a frame (11 = full frame); bit 0 is the start bit.
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input bit glitch, input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2data = bits[i];
      if (glitch && i == 4) begin
        wait_cyc(10); ps2clk = 1'b0; wait_cyc(3); ps2clk = 1'b1; wait_cyc(H - 13);
      end else begin
        wait_cyc(H);
      end
      if (i == 10) model_byte(b, !bad_par && !bad_stop);
      ps2clk = 1'b0;
      wait_cyc(H);
      ps2clk = 1'b1;
    end
    ps2data = 1'b1;
    wait_cyc(2 * H);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(b, 1'b0, 1'b0, 1'b0, 11);
  endtask

  // Compare process: head fields against the model on every valid cycle.
  always @(negedge clk100) begin
    if (run_cmp) begin
      if (frame_err) got_err++;
      if (overflow) got_ovf++;
      if (evt_valid) begin
        vld_cycles++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL evt_unexpected: got %0h expected none", {evt_ext, evt_break, evt_scan});
        end else begin
          check("evt_head", {evt_ext, evt_break, evt_scan}, exp_q[0]);
          if (evt_ready) begin
            got_log.push_back({evt_ext, evt_break, evt_scan});
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("idle_fields", {evt_ext, evt_break, evt_scan}, 0);
      end
    end
  end

  task automatic check_log(input string name, input int idx, input int req);
    if (idx < got_log.size()) check(name, got_log[idx], req);
    else check({name, "_missing"}, got_log.size(), idx + 1);
  endtask

  logic [9:0] typ_exp[$];

  initial begin
    wait_cyc(5);
    check("rst_valid", evt_valid, 0);
    check("rst_scan", evt_scan, 0);
    check("rst_brk", evt_break, 0);
    check("rst_ext", evt_ext, 0);
    check("rst_err", frame_err, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;
    run_cmp = 1'b1;
    evt_ready = 1'b1;
    wait_cyc(20);

    // Single make 1C.
    vld_cycles = 0;
    send_frame(8'h1C);
    check("t1_count", got_log.size(), 1);
    check_log("t1_evt", 0, 10'h01C);
    check("t1_vld_cycles", vld_cycles, 1);
    check("t1_err", got_err, 0);

    // Break and extended break.
    got_log.delete();
    send_frame(8'hF0); send_frame(8'h1C);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    check("t2_count", got_log.size(), 2);
    check_log("t2_brk", 0, 10'h11C);
    check_log("t2_extbrk", 1, 10'h375);

    // Parity error then recovery.
    got_log.delete();
    send_bits(8'h1C, 1'b1, 1'b0, 1'b0, 11);
    check("t3_err", got_err, 1);
    check("t3_noevt", got_log.size(), 0);
    send_frame(8'h29);
    check_log("t3_recover", 0, 10'h029);

    // Start bit of 1 is rejected.
    exp_err++;
    ps2data = 1'b1; wait_cyc(H); ps2clk = 1'b0; wait_cyc(H); ps2clk = 1'b1; wait_cyc(2 * H);
    check("t4_badstart", got_err, 2);

    // Timeout on a partial frame, then recovery.
    got_log.delete();
    model_byte(8'h00, 1'b0);
    send_bits(8'h1C, 1'b0, 1'b0, 1'b0, 4);
    wait_cyc(TMO + 200);
    check("t5_timeout", got_err, 3);
    send_frame(8'h1C);
    check_log("t5_recover", 0, 10'h01C);

    // Overflow with the consumer stalled.
    got_log.delete();
    evt_ready = 1'b0;
    send_frame(8'h15); send_frame(8'h1D); send_frame(8'h24);
    send_frame(8'h2D); send_frame(8'h2C);
    check("t6_ovf", got_ovf, 1);
    check("t6_ovf_model", got_ovf, exp_ovf);
    check("t6_valid", evt_valid, 1);
    evt_ready = 1'b1;
    wait_cyc(20);
    check_log("t6_e0", 0, 10'h015);
    check_log("t6_e1", 1, 10'h01D);
    check_log("t6_e2", 2, 10'h024);
    check_log("t6_e3", 3, 10'h02D);
    check("t6_count", got_log.size(), 4);
    check("t6_drained", evt_valid, 0);

    // Typematic repeats.
    got_log.delete();
    send_frame(8'h1C); send_frame(8'h1C); send_frame(8'h1C);
    send_frame(8'hF0); send_frame(8'h1C); send_frame(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    typ_exp = '{10'h01C, 10'h11C, 10'h01C};
`else
    typ_exp = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
`endif
    check("t7_count", got_log.size(), typ_exp.size());
    for (int i = 0; i < typ_exp.size(); i++) check_log("t7_evt", i, typ_exp[i]);

    // Reset in mid-frame discards the partial frame.
    got_log.delete();
    send_bits(8'h33, 1'b0, 1'b0, 1'b0, 5);
    run_cmp = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_lm_vld = 1'b0;
    wait_cyc(3);
    check("t8_rst_valid", evt_valid, 0);
    check("t8_rst_err", frame_err, 0);
    reset = 1'b0;
    wait_cyc(5);
    run_cmp = 1'b1;
    send_frame(8'h1C);
    check("t8_count", got_log.size(), 1);
    check_log("t8_evt", 0, 10'h01C);

    // Randomized frames with glitches, errors and a jittery consumer.
    rand_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          logic [7:0] b;
          int sel;
          sel = $urandom_range(0, 9);
          if (sel == 0) b = 8'hE0;
          else if (sel == 1) b = 8'hF0;
          else b = 8'($urandom_range(0, 255));
          send_bits(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 2) == 0), 11);
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          wait_cyc(1);
          evt_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    evt_ready = 1'b1;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) wait_cyc(1);
    check("final_drain", exp_q.size(), 0);
    check("final_err", got_err, exp_err);
    check("final_ovf", got_ovf, exp_ovf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
